// File: rtl/pot_scan_ctrl.sv
// Slide-pot scanner and amplifier power sequencer between the SPI A2D and the EQ engine.
// Latency: a setting is written on the edge after cnv_cmplt; each conversion takes IDLE_CYC+2+A2D cycles.
// Backpressure: freeze holds the FSM in GAP before the next strt_cnv; a conversion in flight always completes.
//
// Optional feature: define POT_SMOOTH_EN to low-pass each channel (pot += (res-pot)>>>2 after the first sample).
//
// Ports:
//   clk, rst             system clock, asynchronous active-high reset
//   freeze               inhibit starting new conversions
//   cnv_cmplt, res       A2D completion pulse and its result
//   strt_cnv, chnnl      A2D start pulse and channel (held from strt_cnv through UPDATE)
//   pot_bus, pot_vld     per-channel settings (channel k at [k*RES_W +: RES_W]) and first-sample flags
//   scan_done            one-cycle pulse when the last channel is updated or skipped
//   tmo_err              sticky conversion-timeout flag
//   amp_on               amplifier enable, set after SETTLE_SCANS clean scans, held until rst
module pot_scan_ctrl #(
    parameter int NUM_CH       = 6,
    parameter int RES_W        = 12,
    parameter int CH_W         = 3,
    parameter int IDLE_CYC     = 16,
    parameter int TMO_CYC      = 4096,
    parameter int SETTLE_SCANS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    freeze,
    input  logic                    cnv_cmplt,
    input  logic [RES_W-1:0]        res,
    output logic                    strt_cnv,
    output logic [CH_W-1:0]         chnnl,
    output logic [NUM_CH*RES_W-1:0] pot_bus,
    output logic [NUM_CH-1:0]       pot_vld,
    output logic                    scan_done,
    output logic                    tmo_err,
    output logic                    amp_on
);

    localparam int GAP_W = $clog2(IDLE_CYC + 1);
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam int SC_W  = $clog2(SETTLE_SCANS + 1);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [SC_W-1:0]  SC_FULL  = SC_W'(SETTLE_SCANS);

    typedef enum logic [1:0] {S_GAP, S_START, S_WAIT, S_UPDATE} state_t;

    state_t            state, nxt_state;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [SC_W-1:0]   scan_cnt;
    logic [SC_W-1:0]   scan_cnt_inc;
    logic              scan_err;      // a timeout has hit some channel of the current scan
    logic              gap_end;
    logic              tmo_hit;
    logic              wr_good;
    logic              wr_tmo;
    logic              last_ch;
    logic [NUM_CH-1:0] vld_next;
    logic [RES_W-1:0]  pot_new;

    assign gap_end      = (gap_cnt == GAP_LAST);
    assign tmo_hit      = (tmo_cnt == TMO_LAST);
    // cnv_cmplt beats a timeout expiring in the same cycle
    assign wr_good      = (state == S_WAIT) && cnv_cmplt;
    assign wr_tmo       = (state == S_WAIT) && !cnv_cmplt && tmo_hit;
    assign last_ch      = (chnnl == CH_LAST);
    assign scan_cnt_inc = (scan_cnt == SC_FULL) ? scan_cnt : scan_cnt + 1'b1;

    // pot_vld as it will be after this cycle's write, so amp_on can qualify on the final channel
    always_comb begin
        vld_next = pot_vld;
        for (int k = 0; k < NUM_CH; k++) begin
            if (wr_good && chnnl == CH_W'(k)) begin
                vld_next[k] = 1'b1;
            end
        end
    end

`ifdef POT_SMOOTH_EN
    logic [RES_W-1:0]        cur;
    logic                    cur_vld;
    logic signed [RES_W:0]   diff;
    logic signed [RES_W:0]   step;
    logic signed [RES_W+1:0] sum;

    always_comb begin
        cur     = '0;
        cur_vld = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (chnnl == CH_W'(k)) begin
                cur     = pot_bus[k*RES_W +: RES_W];
                cur_vld = pot_vld[k];
            end
        end
        diff = $signed({1'b0, res}) - $signed({1'b0, cur});
        step = diff >>> 2;                                   // floor division by 4
        sum  = $signed({2'b00, cur}) + $signed({step[RES_W], step});
        if (!cur_vld) begin
            pot_new = res;                                   // first sample loads directly
        end else if (sum[RES_W+1]) begin
            pot_new = '0;
        end else if (sum[RES_W]) begin
            pot_new = '1;
        end else begin
            pot_new = sum[RES_W-1:0];
        end
    end
`else
    assign pot_new = res;
`endif

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_GAP;
        end else begin
            state <= nxt_state;
        end
    end

    // next-state logic
    always_comb begin
        nxt_state = state;
        case (state)
            S_GAP:    if (gap_end && !freeze) nxt_state = S_START;
            S_START:  nxt_state = S_WAIT;
            S_WAIT:   if (cnv_cmplt || tmo_hit) nxt_state = S_UPDATE;
            S_UPDATE: nxt_state = S_GAP;
            default:  nxt_state = S_GAP;
        endcase
    end

    // FSM outputs
    always_comb begin
        strt_cnv  = (state == S_START);
        scan_done = (state == S_UPDATE) && last_ch;
    end

    // sequencing counters and channel pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
            tmo_cnt <= '0;
            chnnl   <= '0;
        end else begin
            case (state)
                S_GAP:    if (!gap_end) gap_cnt <= gap_cnt + 1'b1;
                S_START:  tmo_cnt <= '0;
                S_WAIT:   tmo_cnt <= tmo_cnt + 1'b1;
                S_UPDATE: begin
                    gap_cnt <= '0;
                    chnnl   <= last_ch ? '0 : chnnl + 1'b1;
                end
                default:  gap_cnt <= '0;
            endcase
        end
    end

    // settings store and settle accounting; written on the edge that leaves WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pot_bus  <= '0;
            pot_vld  <= '0;
            tmo_err  <= 1'b0;
            scan_err <= 1'b0;
            scan_cnt <= '0;
            amp_on   <= 1'b0;
        end else begin
            if (wr_good) begin
                pot_vld <= vld_next;
                for (int k = 0; k < NUM_CH; k++) begin
                    if (chnnl == CH_W'(k)) begin
                        pot_bus[k*RES_W +: RES_W] <= pot_new;
                    end
                end
            end
            if (wr_tmo) begin
                tmo_err  <= 1'b1;
                scan_err <= 1'b1;
                scan_cnt <= '0;
            end
            // end of scan: the next scan starts clean, even if this channel just timed out
            if ((wr_good || wr_tmo) && last_ch) begin
                scan_err <= 1'b0;
                if (!scan_err && !wr_tmo) begin
                    scan_cnt <= scan_cnt_inc;
                    if (scan_cnt_inc == SC_FULL && (&vld_next)) begin
                        amp_on <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pot_scan_ctrl.sv
module tb_pot_scan_ctrl;

    localparam int NUM_CH = 6;
    localparam int RES_W  = 12;
    localparam int CH_W   = 3;
    localparam int SETTLE = 4;
    localparam int NB     = NUM_CH * RES_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              freeze;
    logic              cnv_cmplt;
    logic [RES_W-1:0]  res;
    logic              strt_cnv;
    logic [CH_W-1:0]   chnnl;
    logic [NB-1:0]     pot_bus;
    logic [NUM_CH-1:0] pot_vld;
    logic              scan_done;
    logic              tmo_err;
    logic              amp_on;

    pot_scan_ctrl #(
        .NUM_CH(NUM_CH), .RES_W(RES_W), .CH_W(CH_W),
        .IDLE_CYC(16), .TMO_CYC(4096), .SETTLE_SCANS(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .cnv_cmplt(cnv_cmplt), .res(res),
        .strt_cnv(strt_cnv), .chnnl(chnnl), .pot_bus(pot_bus), .pot_vld(pot_vld),
        .scan_done(scan_done), .tmo_err(tmo_err), .amp_on(amp_on)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                ch;
        logic [NB-1:0]     bus;
        logic [NUM_CH-1:0] vld;
        bit                tmo;
        bit                amp;
        int                sd;
    } rec_t;

    rec_t q[$];

    int total = 0;
    int bad   = 0;

    // reference model state
    int                exp_ch;
    logic [RES_W-1:0]  pot_m [NUM_CH];
    logic [NUM_CH-1:0] vld_m;
    int                scan_cnt_m;
    bit                scan_err_m;
    bit                amp_m;
    bit                tmo_m;
    int                scan_idx;
    int                scans_seen;

    // stimulus controls
    int                res_mode;
    int                lat_mode;
    int                drop_scan;
    int                drop_ch;
    int                strt_count = 0;
    int                cd = 0;
    logic [RES_W-1:0]  cd_res;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_ch = 0;
        for (int k = 0; k < NUM_CH; k++) pot_m[k] = '0;
        vld_m      = '0;
        scan_cnt_m = 0;
        scan_err_m = 0;
        amp_m      = 0;
        tmo_m      = 0;
        scan_idx   = 1;
        scans_seen = 0;
        q.delete();
    endtask

    // Called when the A2D sees strt_cnv: choose the response and push the expected outcome.
    task automatic model_step();
        rec_t             r;
        int               ch;
        int               d;
        int               nv;
        logic [RES_W-1:0] v;
        ch = exp_ch;
        chk("strt_chnnl", chnnl, ch);
        r.ch = ch;
        r.sd = 0;
        if (scan_idx == drop_scan && ch == drop_ch) begin
            tmo_m      = 1;
            scan_err_m = 1;
            scan_cnt_m = 0;
            cd         = 0;
        end else begin
            v = (res_mode == 0) ? RES_W'(256 + ch) : RES_W'($urandom);
`ifdef POT_SMOOTH_EN
            if (res_mode == 1 && ch == 0 && scan_idx == 1) v = 12'h000;
            if (res_mode == 1 && ch == 0 && scan_idx == 2) v = 12'hFFF;
            if (vld_m[ch]) begin
                d  = int'(v) - int'(pot_m[ch]);
                nv = int'(pot_m[ch]) + (d >>> 2);
                if (nv < 0) nv = 0;
                if (nv > 4095) nv = 4095;
                pot_m[ch] = RES_W'(nv);
            end else begin
                pot_m[ch] = v;
            end
`else
            d  = 0;
            nv = 0;
            pot_m[ch] = v;
`endif
            vld_m[ch] = 1'b1;
            cd_res    = v;
            cd        = (lat_mode != 0) ? int'($urandom_range(30, 1)) : 20;
        end
        if (ch == NUM_CH - 1) begin
            r.sd = 1;
            if (!scan_err_m && scan_cnt_m < SETTLE) scan_cnt_m++;
            if (scan_cnt_m == SETTLE && vld_m == {NUM_CH{1'b1}}) amp_m = 1;
            scan_err_m = 0;
            scan_idx++;
        end
        exp_ch = (ch + 1) % NUM_CH;
        for (int k = 0; k < NUM_CH; k++) r.bus[k*RES_W +: RES_W] = pot_m[k];
        r.vld = vld_m;
        r.tmo = tmo_m;
        r.amp = amp_m;
        q.push_back(r);
    endtask

    // A2D model: answers each strt_cnv after a latency (or never, for a dropped conversion)
    initial begin
        forever begin
            @(negedge clk);
            cnv_cmplt = 1'b0;
            if (!rst && strt_cnv) begin
                strt_count++;
                model_step();
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    cnv_cmplt = 1'b1;
                    res       = cd_res;
                end
            end
        end
    end

    // Monitor: compares against the head of the expected queue when the DUT writes or advances
    initial begin
        rec_t r;
        int   prev_ch;
        int   sd_cnt;
        prev_ch = 0;
        sd_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_ch = int'(chnnl);
                sd_cnt  = 0;
            end else begin
                if (scan_done) sd_cnt++;
                if (cnv_cmplt && q.size() > 0) begin
                    chk("write_bus", pot_bus, q[0].bus);
                    chk("write_vld", pot_vld, q[0].vld);
                    chk("write_amp", amp_on, q[0].amp);
                    chk("write_scan_done", scan_done, q[0].sd);
                end
                if (int'(chnnl) != prev_ch) begin
                    if (q.size() == 0) begin
                        chk("unexpected_update", 1, 0);
                    end else begin
                        r = q.pop_front();
                        chk("upd_ch", prev_ch, r.ch);
                        chk("upd_next_ch", chnnl, (r.ch + 1) % NUM_CH);
                        chk("upd_bus", pot_bus, r.bus);
                        chk("upd_vld", pot_vld, r.vld);
                        chk("upd_tmo_err", tmo_err, r.tmo);
                        chk("upd_amp", amp_on, r.amp);
                        chk("upd_scan_done_cnt", sd_cnt, r.sd);
                        if (r.ch == NUM_CH - 1) scans_seen++;
                    end
                    sd_cnt  = 0;
                    prev_ch = int'(chnnl);
                end
            end
        end
    end

    task automatic reset_checks();
        chk("rst_strt_cnv", strt_cnv, 0);
        chk("rst_chnnl", chnnl, 0);
        chk("rst_pot_bus", pot_bus, 0);
        chk("rst_pot_vld", pot_vld, 0);
        chk("rst_scan_done", scan_done, 0);
        chk("rst_tmo_err", tmo_err, 0);
        chk("rst_amp_on", amp_on, 0);
    endtask

    task automatic wait_scans(input int n);
        int budget;
        budget = 0;
        while (scans_seen < n && budget < 20000) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (scans_seen < n) chk("wait_scans_timeout", scans_seen, n);
    endtask

    task automatic wait_strt();
        int n0;
        int budget;
        n0     = strt_count;
        budget = 0;
        while (strt_count == n0 && budget < 10000) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (strt_count == n0) chk("wait_strt_timeout", strt_count, n0 + 1);
    endtask

    initial begin
        int cyc;
        bit found;
        int n0;
        rst       = 1'b1;
        freeze    = 1'b0;
        cnv_cmplt = 1'b0;
        res       = '0;
        res_mode  = 0;
        lat_mode  = 0;
        drop_scan = 0;
        drop_ch   = 0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        reset_checks();

        // release reset; count cycles with the release cycle as cycle 1
        rst   = 1'b0;
        cyc   = 1;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (strt_cnv) found = 1;
        end
        chk("first_strt_cycle", cyc, 17);

        wait_scans(1);
        for (int k = 0; k < NUM_CH; k++) begin
            chk($sformatf("scan1_slice%0d", k), pot_bus[k*RES_W +: RES_W], 12'h100 + k);
        end
        chk("scan1_vld", pot_vld, 6'h3F);
        wait_scans(3);
        chk("amp_before_4th", amp_on, 0);
        wait_scans(14);
        chk("amp_after_14", amp_on, 1);

        // reset in the middle of WAIT; the late cnv_cmplt must land in GAP and be ignored
        wait_strt();
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        reset_checks();
        repeat (2) @(negedge clk);
        #1;
        rst       = 1'b0;
        res_mode  = 1;
        lat_mode  = 1;
        drop_scan = 3;
        drop_ch   = 2;
        wait_strt();
        chk("stray_vld", pot_vld, 0);
        chk("stray_bus", pot_bus, 0);

        wait_scans(2);
`ifdef POT_SMOOTH_EN
        chk("smooth_ch0", pot_bus[RES_W-1:0], 12'h3FF);
`endif
        wait_scans(3);
        chk("tmo_err_set", tmo_err, 1);
        wait_scans(6);
        chk("amp_after_6", amp_on, 0);
        wait_scans(7);
        chk("amp_after_7", amp_on, 1);
        wait_scans(8);

        // freeze raised mid-WAIT
        lat_mode = 0;
        wait_strt();
        repeat (3) @(negedge clk);
        #1;
        freeze = 1'b1;
        n0     = strt_count;
        repeat (150) @(negedge clk);
        #1;
        chk("freeze_no_strt", strt_count, n0);
        chk("freeze_inflight_done", q.size(), 0);
        chk("freeze_amp_hold", amp_on, 1);
        freeze = 1'b0;
        @(negedge clk);
        chk("unfreeze_strt", strt_cnv, 1);
        lat_mode = 1;
        wait_scans(scans_seen + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
